// File: rtl/am_mod_pkg.sv
// Shared types, constants and helpers for the parametrised AM modulator.
package am_mod_pkg;

    typedef enum logic [1:0] {
        AM_QUAD_0 = 2'd0,
        AM_QUAD_1 = 2'd1,
        AM_QUAD_2 = 2'd2,
        AM_QUAD_3 = 2'd3
    } am_quad_e;

    localparam logic AM_MODE_AM    = 1'b0;
    localparam logic AM_MODE_DSBSC = 1'b1;
    localparam int   AM_MOD_LAT    = 32'sd4;

    // Clamp a signed value into the dw-bit two's complement range.
    function automatic logic signed [31:0] am_sat(input logic signed [31:0] y, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 32'sd1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 32'sd1));
        if (y > hi) begin
            am_sat = hi;
        end else if (y < lo) begin
            am_sat = lo;
        end else begin
            am_sat = y;
        end
    endfunction

    // Quarter-wave entry round((2^(dw-1)-1)*sin((idx+0.5)*2pi/2^aw)), built with
    // 2^30 fixed-point Taylor terms so it folds to a constant at elaboration.
    function automatic int am_lut_entry(input int idx, input int dw, input int aw);
        longint x;
        longint term;
        longint sum;
        longint amp;
        x    = ((64'sd2 * longint'(idx) + 64'sd1) * 64'sd3373259426) >>> aw;
        term = x;
        sum  = x;
        for (int k = 1; k < 10; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
        return int'((sum * amp + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/am_mod_param_dds.sv
// Carrier DDS: tuning-word register, phase accumulator and quarter-wave sine LUT
// with a registered signed carrier one cycle after the phase is captured.
module am_dds_quarter
    import am_mod_pkg::*;
#(
    parameter int DW     = 12,
    parameter int PW     = 32,
    parameter int LUT_AW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_adv,
    input  logic [PW-1:0]        i_ftw,
    input  logic                 i_ftw_load,
    input  logic                 i_phase_clr,
    output logic signed [DW-1:0] o_carrier
);

    localparam int QN = 2 ** (LUT_AW - 2);

    logic [PW-1:0]        r_phase;
    logic [PW-1:0]        r_ftw;
    logic [LUT_AW-1:0]    r_addr;
    logic                 r_addr_vld;
    logic signed [DW-1:0] r_carrier;
    logic [DW-2:0]        w_lut [QN];
    logic [LUT_AW-3:0]    w_idx;
    logic [DW-2:0]        w_mag;
    logic signed [DW-1:0] w_carrier;

    for (genvar g = 0; g < QN; g++) begin : g_lut
        localparam int ENT = am_lut_entry(g, DW, LUT_AW);
        assign w_lut[g] = (DW-1)'(ENT);
    end

    // Tuning word: a load is only seen by accumulations after the load cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ftw <= {PW{1'b0}};
        end else if (i_ftw_load) begin
            r_ftw <= i_ftw;
        end else begin
            r_ftw <= r_ftw;
        end
    end

    // Phase accumulator; clear beats advance, the sample still sees the old phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= {PW{1'b0}};
            r_addr     <= {LUT_AW{1'b0}};
            r_addr_vld <= 1'b0;
        end else begin
            r_addr_vld <= i_adv;
            if (i_adv) begin
                r_addr <= r_phase[PW-1 -: LUT_AW];
            end else begin
                r_addr <= r_addr;
            end
            if (i_phase_clr) begin
                r_phase <= {PW{1'b0}};
            end else if (i_adv) begin
                r_phase <= r_phase + r_ftw;
            end else begin
                r_phase <= r_phase;
            end
        end
    end

    // Quadrant folding of the quarter-wave table.
    always_comb begin
        w_idx     = r_addr[LUT_AW-3:0];
        w_mag     = w_lut[w_idx];
        w_carrier = signed'({1'b0, w_lut[w_idx]});
        case (am_quad_e'(r_addr[LUT_AW-1 -: 2]))
            AM_QUAD_0: begin
                w_mag     = w_lut[w_idx];
                w_carrier = signed'({1'b0, w_mag});
            end
            AM_QUAD_1: begin
                w_mag     = w_lut[~w_idx];
                w_carrier = signed'({1'b0, w_mag});
            end
            AM_QUAD_2: begin
                w_mag     = w_lut[w_idx];
                w_carrier = -signed'({1'b0, w_mag});
            end
            AM_QUAD_3: begin
                w_mag     = w_lut[~w_idx];
                w_carrier = -signed'({1'b0, w_mag});
            end
            default: begin
                w_mag     = w_lut[w_idx];
                w_carrier = signed'({1'b0, w_mag});
            end
        endcase
    end

    // Registered LUT read, held between samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carrier <= {DW{1'b0}};
        end else if (r_addr_vld) begin
            r_carrier <= w_carrier;
        end else begin
            r_carrier <= r_carrier;
        end
    end

    assign o_carrier = r_carrier;

endmodule

// File: rtl/am_mod_param.sv
// Parametrised AM / DSB-SC modulator with integrated DDS carrier, 4-cycle latency.
// Optional sticky saturation flag (sat_flag/sat_clr) enabled by AM_MOD_SAT_FLAG_EN.
module am_mod_param
    import am_mod_pkg::*;
#(
    parameter int DW     = 12,
    parameter int PW     = 32,
    parameter int LUT_AW = 12,
    parameter int MW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] adc_data,
    input  logic [MW:0]   ma,
    input  logic          mode,
    input  logic [PW-1:0] ftw,
    input  logic          ftw_load,
    input  logic          phase_clr,
    output logic          out_valid,
    output logic [DW-1:0] am_data,
    output logic [DW-1:0] carrier_data
`ifdef AM_MOD_SAT_FLAG_EN
    ,
    input  logic          sat_clr,
    output logic          sat_flag
`endif
);

    localparam logic [DW-1:0]        OFS     = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0] ENV_OFS = {3'b001, {(DW-1){1'b0}}};

    logic                        r_v1, r_v2, r_v3, r_out_valid;
    logic signed [DW-1:0]        r_m1;
    logic [MW:0]                 r_ma1;
    logic                        r_mode1, r_mode2;
    logic signed [DW+1:0]        r_s2;
    logic signed [DW+1:0]        r_y3;
    logic signed [DW-1:0]        r_c3;
    logic [DW-1:0]               r_am_data;
    logic [DW-1:0]               r_carrier_data;
    logic signed [DW-1:0]        w_carrier;
    logic signed [DW+MW+1:0]     w_prod;
    logic signed [DW+1:0]        w_env;
    logic signed [2*DW+1:0]      w_cy;
    logic signed [31:0]          w_sat;

    am_dds_quarter #(.DW(DW), .PW(PW), .LUT_AW(LUT_AW)) u_dds (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (in_valid),
        .i_ftw       (ftw),
        .i_ftw_load  (ftw_load),
        .i_phase_clr (phase_clr),
        .o_carrier   (w_carrier)
    );

    assign w_prod = (DW+MW+2)'(r_m1) * (DW+MW+2)'(signed'({1'b0, r_ma1}));
    assign w_cy   = (2*DW+2)'(w_carrier) * (2*DW+2)'(w_env);
    assign w_sat  = am_sat(32'(r_y3), DW);

    // Envelope: DSB-SC drops the carrier term; a negative envelope is kept.
    always_comb begin
        w_env = r_s2;
        if (r_mode2 == AM_MODE_DSBSC) begin
            w_env = r_s2;
        end else begin
            w_env = r_s2 + ENV_OFS;
        end
    end

    // Valid delay line, one stage per pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_v3        <= r_v2;
            r_out_valid <= r_v3;
        end
    end

    // Data stages: capture, index multiply, carrier multiply; each holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m1    <= {DW{1'b0}};
            r_ma1   <= {(MW+1){1'b0}};
            r_mode1 <= AM_MODE_AM;
            r_s2    <= {(DW+2){1'b0}};
            r_mode2 <= AM_MODE_AM;
            r_y3    <= {(DW+2){1'b0}};
            r_c3    <= {DW{1'b0}};
        end else begin
            if (in_valid) begin
                r_m1    <= signed'(adc_data ^ OFS);
                r_ma1   <= ma;
                r_mode1 <= mode;
            end else begin
                r_m1    <= r_m1;
                r_ma1   <= r_ma1;
                r_mode1 <= r_mode1;
            end
            if (r_v1) begin
                r_s2    <= (DW+2)'(w_prod >>> MW);
                r_mode2 <= r_mode1;
            end else begin
                r_s2    <= r_s2;
                r_mode2 <= r_mode2;
            end
            if (r_v2) begin
                r_y3 <= (DW+2)'(w_cy >>> DW);
                r_c3 <= w_carrier;
            end else begin
                r_y3 <= r_y3;
                r_c3 <= r_c3;
            end
        end
    end

    // Saturate and re-offset into the output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_am_data      <= OFS;
            r_carrier_data <= OFS;
        end else if (r_v3) begin
            r_am_data      <= DW'(w_sat) ^ OFS;
            r_carrier_data <= r_c3 ^ OFS;
        end else begin
            r_am_data      <= r_am_data;
            r_carrier_data <= r_carrier_data;
        end
    end

    assign out_valid    = r_out_valid;
    assign am_data      = r_am_data;
    assign carrier_data = r_carrier_data;

`ifdef AM_MOD_SAT_FLAG_EN
    logic w_clamp;
    logic r_sat_flag;

    assign w_clamp = r_v3 && (w_sat != 32'(r_y3));

    // Sticky clamp indicator; a new clamp wins over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_clamp) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end else begin
            r_sat_flag <= r_sat_flag;
        end
    end

    assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_am_mod_param.sv
// Self-checking bench for am_mod_param: directed sections plus randomized traffic
// compared against a floating-point reference of the modulator equations.
module tb_am_mod_param;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] adc_data = 12'd2048;
    logic [10:0] ma = 11'd0;
    logic        mode = 1'b0;
    logic [31:0] ftw = 32'd0;
    logic        ftw_load = 1'b0;
    logic        phase_clr = 1'b0;
    logic        out_valid;
    logic [11:0] am_data;
    logic [11:0] carrier_data;
`ifdef AM_MOD_SAT_FLAG_EN
    logic        sat_clr = 1'b0;
    logic        sat_flag;
`endif

    typedef struct {
        int due;
        int am;
        int car;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_phase = 32'd0;
    logic [31:0] m_ftw = 32'd0;
    int          last_am = 2048;
    int          last_car = 2048;

    am_mod_param dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .adc_data     (adc_data),
        .ma           (ma),
        .mode         (mode),
        .ftw          (ftw),
        .ftw_load     (ftw_load),
        .phase_clr    (phase_clr),
        .out_valid    (out_valid),
        .am_data      (am_data),
        .carrier_data (carrier_data)
`ifdef AM_MOD_SAT_FLAG_EN
        ,
        .sat_clr      (sat_clr),
        .sat_flag     (sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Carrier straight from the full-cycle sine at the bin centre.
    function automatic int ref_carrier(input logic [31:0] ph);
        real a;
        real v;
        int  mag;
        a   = (real'(ph[31:20]) + 0.5) * 2.0 * PI / 4096.0;
        v   = 2047.0 * $sin(a);
        mag = $rtoi($floor(((v < 0.0) ? -v : v) + 0.5));
        return (v < 0.0) ? -mag : mag;
    endfunction

    function automatic int ref_am(input int c, input int adc, input int ma_v, input bit md);
        int m;
        int s;
        int env;
        int y;
        m   = adc - 2048;
        s   = (m * ma_v) >>> 10;
        env = md ? s : 2048 + s;
        y   = (c * env) >>> 12;
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        return y + 2048;
    endfunction

    task automatic step(input bit iv, input int adc, input int ma_v, input bit md,
                        input bit ld, input logic [31:0] f, input bit clr);
        exp_t e;
        int   c;
        @(negedge clk);
        in_valid  = iv;
        adc_data  = adc[11:0];
        ma        = ma_v[10:0];
        mode      = md;
        ftw_load  = ld;
        ftw       = f;
        phase_clr = clr;
        if (iv) begin
            c     = ref_carrier(m_phase);
            e.due = cyc + 4;
            e.am  = ref_am(c, adc, ma_v, md);
            e.car = c + 2048;
            q.push_back(e);
        end
        if (clr) m_phase = 32'd0;
        else if (iv) m_phase = m_phase + m_ftw;
        if (ld) m_ftw = f;
        @(posedge clk);
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            check("out_valid_hi", out_valid, 32'd1);
            check("am_data", am_data, q[0].am);
            check("carrier_data", carrier_data, q[0].car);
            last_am  = q[0].am;
            last_car = q[0].car;
            void'(q.pop_front());
        end else begin
            check("out_valid_lo", out_valid, 32'd0);
            check("am_hold", am_data, last_am);
            check("carrier_hold", carrier_data, last_car);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2048, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        check("drain_empty", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        ftw_load  = 1'b0;
        phase_clr = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_am_data", am_data, 32'd2048);
        check("rst_carrier", carrier_data, 32'd2048);
        q.delete();
        m_phase  = 32'd0;
        m_ftw    = 32'd0;
        last_am  = 2048;
        last_car = 2048;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset, then a lone sample to pin the latency.
        do_reset();
        idle(2);
        step(1'b1, 2048, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        idle(6);

        // Static phase: c = +2 every sample.
        for (int i = 0; i < 8; i++) step(1'b1, $urandom_range(0, 4095), 0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("static_last_am", last_am, 32'd2049);

        // Quarter-cycle tone; load shares a valid cycle, so that sample still uses ftw = 0.
        step(1'b1, 2048, 0, 1'b0, 1'b1, 32'h4000_0000, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 2048, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        drain();

        // Full modulation, then realign phase with a clear.
        step(1'b0, 2048, 0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 4095, 1024, 1'b0, 1'b0, 32'd0, 1'b0);
        drain();
`ifdef AM_MOD_SAT_FLAG_EN
        check("sat_flag_clear", sat_flag, 32'd0);
`endif

        // Overmodulation drives the output into the clamp.
        for (int i = 0; i < 8; i++) step(1'b1, 4095, 2047, 1'b0, 1'b0, 32'd0, 1'b0);
        drain();
`ifdef AM_MOD_SAT_FLAG_EN
        check("sat_flag_set", sat_flag, 32'd1);
        sat_clr = 1'b1;
        idle(1);
        sat_clr = 1'b0;
        idle(1);
        check("sat_flag_cleared", sat_flag, 32'd0);
`endif

        // DSB-SC at mid-scale input is silent at every phase.
        step(1'b0, 2048, 0, 1'b1, 1'b1, 32'h1357_9BDF, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 2048, $urandom_range(0, 2047), 1'b1, 1'b0, 32'd0, 1'b0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 4095), $urandom_range(0, 2047),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 15) == 0));
        end

        // Reset in the middle of a burst, then restart from phase 0.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 4095), 1024, 1'b0, 1'b0, 32'd0, 1'b0);
        do_reset();
        step(1'b0, 2048, 0, 1'b0, 1'b1, 32'h4000_0000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(0, 4095), $urandom_range(0, 2047), 1'b0, 1'b0, 32'd0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_mod_param.md
Name: am_mod_param

Overview:
- Parametrised AM modulator, successor to the fixed 12-bit AM modulator.
- Integrates the carrier DDS: phase accumulator plus quarter-wave sine LUT.
- Takes offset-binary baseband samples with a valid strobe, a run-time modulation index that allows overmodulation, a run-time carrier tuning word, and a mode select (AM / DSB-SC).
- Produces offset-binary DAC samples through a fixed-latency pipeline with saturation.

Parameters:
- DW, 12: sample width for baseband in, carrier and output; offset binary, mid-scale 2^(DW-1).
- PW, 32: phase accumulator width.
- LUT_AW, 12: phase bits used for full-cycle LUT addressing; the LUT stores 2^(LUT_AW-2) quarter-wave entries.
- MW, 10: fractional bits of the modulation index; ma = 2^MW means index 1.0.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: baseband sample strobe; advances the pipeline and the phase.
- adc_data, input, DW: baseband sample, offset binary.
- ma, input, MW+1: modulation index, unsigned, 0 to (2^(MW+1)-1)/2^MW.
- mode, input, 1: 0 = AM (carrier present), 1 = DSB-SC.
- ftw, input, PW: frequency tuning word.
- ftw_load, input, 1: latch ftw.
- phase_clr, input, 1: synchronous phase accumulator clear.
- out_valid, output, 1: am_data valid.
- am_data, output, DW: modulated output, offset binary.
- carrier_data, output, DW: test port; signed carrier aligned with am_data, re-offset to offset binary.

Behaviour:
- Reset values: am_data = 2^(DW-1), carrier_data = 2^(DW-1), out_valid = 0, phase = 0, ftw register = 0, all stage valids = 0. Reset asserted mid-stream discards all in-flight samples.
- ftw register:
  - Loads on ftw_load.
  - The new value is first used by the accumulation at the next in_valid after the load cycle.
  - ftw_load and in_valid in the same cycle: that in_valid's accumulation uses the old ftw.
- Phase accumulator:
  - On in_valid, the sample uses the current phase P. P <= P + ftw (mod 2^PW).
  - phase_clr forces P <= 0 and overrides accumulation when both occur in the same cycle.
  - LUT address = P[PW-1 -: LUT_AW].
- Quarter-wave LUT:
  - entry[i] = round((2^(DW-1)-1) * sin((i+0.5) * 2pi / 2^LUT_AW)), for i in 0..2^(LUT_AW-2)-1.
  - The top 2 address bits select the quadrant q; idx = the low LUT_AW-2 bits.
  - q0: +entry[idx]. q1: +entry[~idx]. q2: -entry[idx]. q3: -entry[~idx].
  - Carrier c is signed DW; it is never exactly 0.
- Arithmetic, all signed with floor (arithmetic-shift) truncation:
  - m = adc_data - 2^(DW-1).
  - s = (m * ma) >>> MW.
  - env = 2^(DW-1) + s when mode = 0; env = s when mode = 1. env is DW+2 bits signed.
  - y = (c * env) >>> DW.
  - Clamp y to [-2^(DW-1), 2^(DW-1)-1], then am_data = y + 2^(DW-1).
  - Negative env (overmodulation) yields phase reversal, not clamping of env.
- Pipeline:
  - 4 registered stages: phase/input capture, LUT read, index multiply, carrier multiply, then saturate/offset into the output register.
  - out_valid is a copy of in_valid delayed exactly 4 cycles.
  - am_data and carrier_data update only when out_valid = 1, and hold otherwise.
  - Back-to-back in_valid is sustained at 1 sample per clock.
- mode and ma are sampled with the sample at capture, so they change cleanly per sample.

Optional Feature:
- Macro: AM_MOD_SAT_FLAG_EN.
- Defined:
  - Adds output sat_flag (1) and input sat_clr (1).
  - sat_flag goes sticky-high on the cycle after any output sample is clamped.
  - sat_clr clears it; a set in the same cycle as sat_clr wins.
  - Reset value of sat_flag is 0.
- Undefined: neither port exists; clamping behaviour is identical.

Decomposition:
- Shared package am_mod_pkg:
  - quadrant encoding constants;
  - mode constants (AM_MODE_AM = 0, AM_MODE_DSBSC = 1);
  - pipeline latency constant AM_MOD_LAT = 4;
  - saturate function.
- One sub-module: am_dds_quarter. It contains the accumulator, ftw register, phase_clr and quarter-wave LUT, and has 1-cycle registered LUT output.

Test Plan (defaults DW=12, PW=32, MW=10, LUT_AW=12):
- Reset and latency:
  - Hold rst low, then release: am_data = 2048, out_valid = 0.
  - Single in_valid pulse at cycle t: out_valid high only at t+4.
- Static phase:
  - ftw = 0, ma = 0, mode = 0, continuous valid.
  - Expect c = +2 at address 0, so am_data = 2049 every sample.
- Quarter-cycle tone:
  - ftw = 2^30, ma = 0, mode = 0.
  - Carriers 2, 2047, -2, -2047.
  - am_data repeats 2049, 3071, 2047, 1024.
- Full modulation:
  - ftw = 2^30, adc = 4095, ma = 1024: s = 2047, env = 4095.
  - At c = 2047: am_data = 4094, no clamp.
- Overmodulation:
  - adc = 4095, ma = 2047: s = 4092, env = 6140.
  - At c = 2047: y = 3068, clamped, so am_data = 4095 and sat_flag = 1 (macro defined).
  - sat_clr returns sat_flag to 0.
- DSB-SC and mid-stream reset:
  - mode = 1, adc = 2048: am_data = 2048 for all phases.
  - Assert rst during a streaming burst: out_valid drops immediately, am_data = 2048.
  - After release, the first output appears 4 cycles after the next in_valid, starting at phase 0.
